// File: rtl/inst_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// inst_prefetch_buffer
//
// Single-entry next-line instruction prefetch buffer. The icache asks for a
// line with prefetch/prefetch_addr. The buffer reads the line from memory
// whenever the memory port is not owned by a demand miss. It then holds the
// line until the icache installs or rejects it with flush_prefetch. Only one
// request is tracked at a time, and requests that arrive while busy are
// dropped.
//
// Optional feature:
//   INST_PREFETCH_PAGE_GUARD_EN - when defined, a request whose line is the
//   first line of a 4 KiB page (prefetch_addr[11:5] == 0) is dropped. Such a
//   line is usually a sequential run-off into a page that may not be mapped.
//
// Ports:
//   clk              sole clock, rising edge
//   rst              asynchronous active-high reset
//   prefetch         next-line request strobe (honoured only when idle)
//   prefetch_addr    requested address (aligned down to 32 bytes)
//   flush_prefetch   discard the buffered or in-flight line
//   mem_busy         demand miss owns the memory port
//   pf_mem_resp      memory read-complete strobe
//   pf_mem_rdata     returned line, valid with pf_mem_resp
//   pf_mem_read      read request, held until pf_mem_resp
//   pf_mem_addr      read address (always the captured address)
//   active_prefetch  prefetch in flight (WAIT/FETCH/DRAIN)
//   prefetch_rvalid  buffered line ready for install
//   prefetch_raddr   address of buffered line
//   prefetch_rdata   buffered line data
// ---------------------------------------------------------------------------
module inst_prefetch_buffer #(
    parameter int CACHE_LINE_SIZE = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prefetch,
    input  logic [31:0]                prefetch_addr,
    input  logic                       flush_prefetch,
    input  logic                       mem_busy,
    input  logic                       pf_mem_resp,
    input  logic [CACHE_LINE_SIZE-1:0] pf_mem_rdata,
    output logic                       pf_mem_read,
    output logic [31:0]                pf_mem_addr,
    output logic                       active_prefetch,
    output logic                       prefetch_rvalid,
    output logic [31:0]                prefetch_raddr,
    output logic [CACHE_LINE_SIZE-1:0] prefetch_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        FETCH = 3'd2,
        VALID = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t                     state, state_next;
    logic [31:0]                addr_q;
    logic [CACHE_LINE_SIZE-1:0] line_q;
    logic                       addr_load;
    logic                       line_load;
    logic                       page_drop;

    // The low five address bits only select a byte within the line.
    logic unused_addr_bits;
    assign unused_addr_bits = ^prefetch_addr[4:0];

`ifdef INST_PREFETCH_PAGE_GUARD_EN
    assign page_drop = (prefetch_addr[11:5] == 7'd0);
`else
    assign page_drop = 1'b0;
`endif

    // NOTE: all clocked state uses non-blocking assignments. Every register
    // then samples the values from before the edge, whatever order the
    // statements are written in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            line_q <= '0;
        end else begin
            state <= state_next;
            if (addr_load) addr_q <= {prefetch_addr[31:5], 5'b0};
            if (line_load) line_q <= pf_mem_rdata;
        end
    end

    // NOTE: each output of this block gets a default before the case
    // statement. A path that leaves a variable unassigned would otherwise
    // infer a latch.
    always_comb begin
        state_next = state;
        addr_load  = 1'b0;
        line_load  = 1'b0;
        case (state)
            IDLE: begin
                if (prefetch && !page_drop) begin
                    addr_load  = 1'b1;
                    state_next = mem_busy ? WAIT : FETCH;
                end
            end
            WAIT: begin
                if (flush_prefetch)  state_next = IDLE;
                else if (!mem_busy)  state_next = FETCH;
            end
            FETCH: begin
                // A flush in the same cycle as the response turns that
                // response into the drain completion, so the data is discarded.
                if (pf_mem_resp) begin
                    line_load  = !flush_prefetch;
                    state_next = flush_prefetch ? IDLE : VALID;
                end else if (flush_prefetch) begin
                    state_next = DRAIN;
                end
            end
            VALID: begin
                if (flush_prefetch) state_next = IDLE;
            end
            DRAIN: begin
                // The read must still complete, or the memory port would be
                // left with an orphaned transaction.
                if (pf_mem_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // All outputs are decoded from registered state, so reset clears them
    // without waiting for a clock edge.
    assign pf_mem_read     = (state == FETCH) || (state == DRAIN);
    assign pf_mem_addr     = addr_q;
    assign active_prefetch = (state == WAIT) || (state == FETCH) || (state == DRAIN);
    assign prefetch_rvalid = (state == VALID);
    assign prefetch_raddr  = addr_q;
    assign prefetch_rdata  = line_q;

endmodule
